// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded fields for the execute stage,
// converts condition-failed or invalid instructions into bubbles, and counts
// instructions killed by a failed condition.
module id_ex_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              cond_state,
    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic [3:0]        id_exe_cmd,
    input  logic              id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [11:0]       id_shift_operand,
    input  logic [23:0]       id_signed_imm_24,
    input  logic [3:0]        id_dest,
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic [3:0]        id_status,
    input  logic              cnt_clr,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_b,
    output logic              ex_s,
    output logic [3:0]        ex_exe_cmd,
    output logic              ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic [11:0]       ex_shift_operand,
    output logic [23:0]       ex_signed_imm_24,
    output logic [3:0]        ex_dest,
    output logic [3:0]        ex_src1,
    output logic [3:0]        ex_src2,
    output logic              ex_valid,
    output logic              ex_carry_in,
    output logic [CNT_W-1:0]  squash_cnt
);

    typedef enum logic {SlotEmpty, SlotLive} slotState_e;

    slotState_e       slotQ, slotD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             loadEdge;
    logic             passLoad;
    logic             killLoad;

    // Qualify the decode slot for this edge.
    always_comb begin
        loadEdge = !flush && !freeze;
        passLoad = id_valid && cond_state;
        killLoad = id_valid && !cond_state;
    end

    // Slot occupancy next-state: flush empties, freeze holds, load follows pass/kill.
    always_comb begin
        slotD = slotQ;
        if (flush) begin
            slotD = SlotEmpty;
        end else if (!freeze) begin
            slotD = passLoad ? SlotLive : SlotEmpty;
        end
    end

    // Squash counter next-state: clear wins over everything, saturates at all-ones.
    always_comb begin
        cntD = cntQ;
        if (cnt_clr) begin
            cntD = '0;
        end else if (loadEdge && killLoad && (cntQ != {CNT_W{1'b1}})) begin
            cntD = cntQ + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slotQ <= SlotEmpty;
            cntQ  <= '0;
        end else begin
            slotQ <= slotD;
            cntQ  <= cntD;
        end
    end

    // Payload register: flush zeroes, freeze holds, load captures (controls gated on pass).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_wb_en         <= 1'b0;
            ex_mem_r_en      <= 1'b0;
            ex_mem_w_en      <= 1'b0;
            ex_b             <= 1'b0;
            ex_s             <= 1'b0;
            ex_exe_cmd       <= '0;
            ex_imm           <= 1'b0;
            ex_pc            <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_shift_operand <= '0;
            ex_signed_imm_24 <= '0;
            ex_dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_carry_in      <= 1'b0;
        end else if (flush) begin
            ex_wb_en         <= 1'b0;
            ex_mem_r_en      <= 1'b0;
            ex_mem_w_en      <= 1'b0;
            ex_b             <= 1'b0;
            ex_s             <= 1'b0;
            ex_exe_cmd       <= '0;
            ex_imm           <= 1'b0;
            ex_pc            <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_shift_operand <= '0;
            ex_signed_imm_24 <= '0;
            ex_dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_carry_in      <= 1'b0;
        end else if (!freeze) begin
            // Killed instructions still carry operands; only their side effects are masked.
            ex_wb_en         <= id_wb_en && passLoad;
            ex_mem_r_en      <= id_mem_r_en && passLoad;
            ex_mem_w_en      <= id_mem_w_en && passLoad;
            ex_b             <= id_b && passLoad;
            ex_s             <= id_s && passLoad;
            ex_exe_cmd       <= id_exe_cmd;
            ex_imm           <= id_imm;
            ex_pc            <= id_pc;
            ex_val_rn        <= id_val_rn;
            ex_val_rm        <= id_val_rm;
            ex_shift_operand <= id_shift_operand;
            ex_signed_imm_24 <= id_signed_imm_24;
            ex_dest          <= id_dest;
            ex_src1          <= id_src1;
            ex_src2          <= id_src2;
            ex_carry_in      <= id_status[2];
        end
    end

    // Slot state and counter drive the outputs directly from flops.
    always_comb begin
        ex_valid   = (slotQ == SlotLive);
        squash_cnt = cntQ;
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: stimulus pushes reference-model results,
// an independent monitor pops and compares one entry per clock edge.
module tb_id_ex_reg;

    logic        clk;
    logic        rst;
    logic        freeze, flush, cond_state, id_valid, cnt_clr;
    logic        id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm;
    logic [3:0]  id_exe_cmd, id_dest, id_src1, id_src2, id_status;
    logic [31:0] id_pc, id_val_rn, id_val_rm;
    logic [11:0] id_shift_operand;
    logic [23:0] id_signed_imm_24;

    logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
    logic [3:0]  ex_exe_cmd, ex_dest, ex_src1, ex_src2;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm_24;
    logic        ex_valid, ex_carry_in;
    logic [15:0] squash_cnt;

    typedef struct packed {
        logic        valid;
        logic        wb, mr, mw, b, s;
        logic [3:0]  cmd;
        logic        imm;
        logic [31:0] pc, rn, rm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  dest, src1, src2;
        logic        carry;
        logic [15:0] cnt;
    } exp_t;

    exp_t mdl;
    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .cond_state(cond_state),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_exe_cmd(id_exe_cmd),
        .id_imm(id_imm), .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
        .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_status(id_status),
        .cnt_clr(cnt_clr), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_exe_cmd(ex_exe_cmd),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
        .ex_shift_operand(ex_shift_operand), .ex_signed_imm_24(ex_signed_imm_24),
        .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_valid(ex_valid),
        .ex_carry_in(ex_carry_in), .squash_cnt(squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t sampleDut();
        exp_t a;
        a.valid = ex_valid;  a.wb = ex_wb_en;  a.mr = ex_mem_r_en;  a.mw = ex_mem_w_en;
        a.b = ex_b;  a.s = ex_s;  a.cmd = ex_exe_cmd;  a.imm = ex_imm;  a.pc = ex_pc;
        a.rn = ex_val_rn;  a.rm = ex_val_rm;  a.shift = ex_shift_operand;
        a.simm = ex_signed_imm_24;  a.dest = ex_dest;  a.src1 = ex_src1;  a.src2 = ex_src2;
        a.carry = ex_carry_in;  a.cnt = squash_cnt;
        return a;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every edge presents a new register state; compare against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("scoreboard", 256'(sampleDut()), 256'(e));
        end
    end

    task automatic randFields();
        id_wb_en = 1'($urandom);  id_mem_r_en = 1'($urandom);  id_mem_w_en = 1'($urandom);
        id_b = 1'($urandom);  id_s = 1'($urandom);  id_imm = 1'($urandom);
        id_exe_cmd = 4'($urandom);  id_dest = 4'($urandom);  id_src1 = 4'($urandom);
        id_src2 = 4'($urandom);  id_status = 4'($urandom);  id_pc = $urandom;
        id_val_rn = $urandom;  id_val_rm = $urandom;  id_shift_operand = 12'($urandom);
        id_signed_imm_24 = 24'($urandom);
    endtask

    // Drive control inputs, predict the next register state, then advance one cycle.
    task automatic commit(input bit fz, input bit fl, input bit clr, input bit v, input bit c);
        exp_t nxt;
        bit   live;
        freeze = fz;  flush = fl;  cnt_clr = clr;  id_valid = v;  cond_state = c;
        nxt = mdl;
        live = v && c;
        if (fl) begin
            nxt = '0;
            nxt.cnt = mdl.cnt;
        end else if (!fz) begin
            nxt.valid = live;
            nxt.wb = live & id_wb_en;  nxt.mr = live & id_mem_r_en;
            nxt.mw = live & id_mem_w_en;  nxt.b = live & id_b;  nxt.s = live & id_s;
            nxt.cmd = id_exe_cmd;  nxt.imm = id_imm;  nxt.pc = id_pc;  nxt.rn = id_val_rn;
            nxt.rm = id_val_rm;  nxt.shift = id_shift_operand;  nxt.simm = id_signed_imm_24;
            nxt.dest = id_dest;  nxt.src1 = id_src1;  nxt.src2 = id_src2;
            nxt.carry = id_status[2];
            if (v && !c && mdl.cnt < 16'hFFFF) nxt.cnt = mdl.cnt + 16'd1;
        end
        if (clr) nxt.cnt = 16'd0;
        mdl = nxt;
        expQ.push_back(nxt);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        freeze = 0;  flush = 0;  cnt_clr = 0;  id_valid = 0;  cond_state = 0;
        randFields();
        mdl = '0;
        #2;
        check("reset_state", 256'(sampleDut()), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed pass load.
        randFields();
        id_wb_en = 1;  id_dest = 4'h3;  id_val_rn = 32'h0000_0010;
        commit(0, 0, 0, 1, 1);
        check("pass_valid", 256'(ex_valid), 256'(1));
        check("pass_dest", 256'(ex_dest), 256'(3));
        check("pass_rn", 256'(ex_val_rn), 256'(32'h10));

        // Same load, condition failed.
        commit(0, 0, 0, 1, 0);
        check("kill_valid", 256'(ex_valid), 256'(0));
        check("kill_wb", 256'(ex_wb_en), 256'(0));
        check("kill_dest", 256'(ex_dest), 256'(3));
        check("kill_cnt", 256'(squash_cnt), 256'(1));

        // Freeze for three cycles with changing inputs, then release.
        randFields();
        commit(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            randFields();
            commit(1, 0, 0, 1, $urandom_range(0, 1) == 1);
        end
        randFields();
        commit(0, 0, 0, 1, 1);

        // Flush and freeze together on a live slot.
        randFields();
        commit(1, 1, 0, 1, 0);
        check("flush_valid", 256'(ex_valid), 256'(0));
        check("flush_cnt", 256'(squash_cnt), 256'(1));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            randFields();
            commit($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1);
        end

        // Saturation: clear, 65535 kills, one more kill, then kill with clear.
        commit(0, 0, 1, 0, 0);
        for (int i = 0; i < 65535; i++) begin
            randFields();
            commit(0, 0, 0, 1, 0);
        end
        check("sat_reach", 256'(squash_cnt), 256'(16'hFFFF));
        commit(0, 0, 0, 1, 0);
        check("sat_hold", 256'(squash_cnt), 256'(16'hFFFF));
        commit(0, 0, 1, 1, 0);
        check("clr_over_kill", 256'(squash_cnt), 256'(0));

        // Asynchronous reset between edges with a live slot.
        randFields();
        commit(0, 0, 0, 1, 0);
        randFields();
        commit(0, 0, 0, 1, 1);
        check("pre_rst_valid", 256'(ex_valid), 256'(1));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", 256'(sampleDut()), 256'(0));
        mdl = '0;
        @(negedge clk);
        rst = 1'b1;
        randFields();
        commit(0, 0, 0, 1, 1);
        check("post_rst_valid", 256'(ex_valid), 256'(1));

        repeat (3) @(negedge clk);
        check("queue_drained", 256'(expQ.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, 32, width of PC and operand values.
REQ-002 Parameter CNT_W, 16, width of squash counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 freeze  in  1  hazard stall; hold all state.
REQ-006 flush  in  1  branch-taken flush; insert bubble.
REQ-007 cond_state  in  1  condition-pass result for the instruction in decode.
REQ-008 id_valid  in  1  decode slot holds a real instruction.
REQ-009 id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s  in  1 each  decoded control bits.
REQ-010 id_exe_cmd  in  4  ALU command; id_imm  in  1  immediate select.
REQ-011 id_pc, id_val_rn, id_val_rm  in  DATA_W each  PC+4 and register-file reads.
REQ-012 id_shift_operand  in  12; id_signed_imm_24  in  24; id_dest, id_src1, id_src2  in  4 each.
REQ-013 id_status  in  4  flags {z,c,n,v}, bit 2 = carry.
REQ-014 cnt_clr  in  1  synchronous clear of squash counter.
REQ-015 ex_* outputs  out  same widths as each id_* input above (except id_valid, id_status).
REQ-016 ex_valid  out  1  execute slot holds a live instruction.
REQ-017 ex_carry_in  out  1  registered carry for ADC/SBC.
REQ-018 squash_cnt  out  CNT_W  count of instructions killed by a failed condition.

Function
REQ-019 Every output SHALL be registered; no combinational input-to-output path.
REQ-020 Per-edge priority SHALL be: flush > freeze > load.
REQ-021 Flush SHALL set ex_valid and all control outputs (wb_en, mem_r_en, mem_w_en, b, s) to 0 and all data/address outputs to 0, regardless of freeze.
REQ-022 Freeze (flush=0) SHALL hold every ex_* output, ex_carry_in and squash_cnt (except cnt_clr, which still clears).
REQ-023 Load SHALL capture all id_* data/address fields and id_status[2] into ex_carry_in with 1-cycle latency.
REQ-024 Load SHALL set ex_valid = id_valid & cond_state.
REQ-025 Load SHALL force all five control outputs to 0 when id_valid=0 or cond_state=0; otherwise copy them.
REQ-026 ex_exe_cmd and operand fields SHALL be captured even for killed instructions (harmless, no write side effect).
REQ-027 squash_cnt SHALL increment by 1 on a load edge with id_valid=1 and cond_state=0.
REQ-028 squash_cnt SHALL saturate at all-ones; no wrap.
REQ-029 cnt_clr SHALL zero squash_cnt next edge and take priority over increment, freeze and flush.
REQ-030 Flush or freeze edges SHALL NOT increment squash_cnt.
REQ-031 Two-state slot FSM: EMPTY (ex_valid=0) / LIVE (ex_valid=1); EMPTY->LIVE on load with pass; LIVE->EMPTY on flush or load with kill/invalid; freeze holds state.

Reset
REQ-032 rst low SHALL immediately clear all outputs to 0 (ex_valid=0, squash_cnt=0) independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard the held instruction; first edge after release behaves as a normal load.

Verification
REQ-034 Load id_valid=1, cond_state=1, wb_en=1, dest=4'h3, val_rn=32'h0000_0010 -> next edge ex_valid=1, ex_wb_en=1, ex_dest=3, ex_val_rn=0x10.
REQ-035 Same load with cond_state=0 -> ex_valid=0, all five controls 0, ex_dest=3 still captured, squash_cnt 0->1.
REQ-036 freeze=1 for 3 cycles with changing id_* -> outputs unchanged; release -> new values next edge.
REQ-037 flush=1 and freeze=1 same edge with live slot -> ex_valid=0, all outputs 0, squash_cnt unchanged.
REQ-038 Preload squash_cnt to 0xFFFF via 65535 kills, kill again -> stays 0xFFFF; assert cnt_clr alongside a kill -> 0x0000.
REQ-039 Drive rst low between edges with ex_valid=1 -> outputs 0 without clock edge; release, load pass -> ex_valid=1 next edge.
